// File: rtl/pixie_dma_fb_writer_if.sv
// CPU-facing bus of the PIXIE DMA front end: machine-cycle strobe, state code, data,
// display control, and the timing and framebuffer-write outputs.
`timescale 1ns/1ps
interface pixie_dma_fb_writer_if;
    logic       ce;
    logic [1:0] sc;
    logic [7:0] data;
    logic       disp_on;
    logic       disp_off;
    logic       dmao;
    logic       int_n;
    logic       efx;
    logic       fb_write_en;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;

    modport master (
        output ce, sc, data, disp_on, disp_off,
        input  dmao, int_n, efx, fb_write_en, fb_addr, fb_data
    );

    modport slave (
        input  ce, sc, data, disp_on, disp_off,
        output dmao, int_n, efx, fb_write_en, fb_addr, fb_data
    );
endinterface

// File: rtl/pixie_dma_fb_writer.sv
// CDP1861-style timing toward the CDP1802 (DMA-out, interrupt, EF1) and the
// write port of the 1 KiB framebuffer fed by the captured DMA-out bytes.
`timescale 1ns/1ps
module pixie_dma_fb_writer #(
    parameter int CYCLES_PER_LINE   = 14,
    parameter int LINES_PER_FRAME   = 262,
    parameter int FIRST_ACTIVE_LINE = 64,
    parameter int ACTIVE_LINES      = 128,
    parameter int BYTES_PER_LINE    = 8,
    parameter int DMA_START_CYCLE   = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pixie_dma_fb_writer_if.slave    bus
);
    localparam int CW = $clog2(CYCLES_PER_LINE);
    localparam int LW = $clog2(LINES_PER_FRAME);
    localparam int BW = $clog2(BYTES_PER_LINE + 1);
    localparam int AW = $clog2(BYTES_PER_LINE);
    localparam int RW = 10 - AW;

    localparam logic [CW-1:0] CYCLE_LAST = CW'(CYCLES_PER_LINE - 1);
    localparam logic [CW-1:0] DMA_START  = CW'(DMA_START_CYCLE);
    localparam logic [LW-1:0] LINE_LAST  = LW'(LINES_PER_FRAME - 1);
    localparam logic [LW-1:0] ACT_FIRST  = LW'(FIRST_ACTIVE_LINE);
    localparam logic [LW-1:0] ACT_END    = LW'(FIRST_ACTIVE_LINE + ACTIVE_LINES);
    localparam logic [LW-1:0] INT_FIRST  = LW'(FIRST_ACTIVE_LINE - 2);
    localparam logic [LW-1:0] INT_LAST   = LW'(FIRST_ACTIVE_LINE - 1);
    localparam logic [LW-1:0] EFX_TOP    = LW'(FIRST_ACTIVE_LINE - 4);
    localparam logic [LW-1:0] EFX_BOT    = LW'(FIRST_ACTIVE_LINE + ACTIVE_LINES - 4);
    localparam logic [BW-1:0] BYTE_MAX   = BW'(BYTES_PER_LINE);

    logic [CW-1:0] cycle_reg;
    logic [LW-1:0] line_reg;
    logic [BW-1:0] byte_reg;
    logic          enable_reg;
    logic          dmao_reg;
    logic          int_n_reg;
    logic          efx_reg;
    logic          fb_write_en_reg;
    logic [9:0]    fb_addr_reg;
    logic [7:0]    fb_data_reg;

    logic          active_line;
    logic          byte_room;
    logic          capture;
    logic [RW-1:0] row;

    always_comb begin
        active_line = (line_reg >= ACT_FIRST) && (line_reg < ACT_END);
        byte_room   = byte_reg < BYTE_MAX;
        row         = RW'(line_reg - ACT_FIRST);
        capture     = bus.ce && (bus.sc == 2'b10) && enable_reg && active_line && byte_room;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_reg       <= '0;
            line_reg        <= '0;
            byte_reg        <= '0;
            enable_reg      <= 1'b0;
            dmao_reg        <= 1'b0;
            int_n_reg       <= 1'b1;
            efx_reg         <= 1'b0;
            fb_write_en_reg <= 1'b0;
            fb_addr_reg     <= '0;
            fb_data_reg     <= '0;
        end else begin
            // disp_off takes priority when both control pulses coincide
            if (bus.disp_off)
                enable_reg <= 1'b0;
            else if (bus.disp_on)
                enable_reg <= 1'b1;

            fb_write_en_reg <= capture;
            if (capture) begin
                fb_addr_reg <= {row, byte_reg[AW-1:0]};
                fb_data_reg <= bus.data;
            end

            // the line wrap clears the byte count even if the last cycle also captured
            if (bus.ce) begin
                if (cycle_reg == CYCLE_LAST) begin
                    cycle_reg <= '0;
                    byte_reg  <= '0;
                    line_reg  <= (line_reg == LINE_LAST) ? '0 : line_reg + LW'(1);
                end else begin
                    cycle_reg <= cycle_reg + CW'(1);
                    if (capture)
                        byte_reg <= byte_reg + BW'(1);
                end
            end

            dmao_reg  <= enable_reg && active_line && (cycle_reg >= DMA_START) && byte_room;
            int_n_reg <= !(enable_reg && ((line_reg == INT_FIRST) || (line_reg == INT_LAST)));
            efx_reg   <= ((line_reg >= EFX_TOP) && (line_reg < ACT_FIRST)) ||
                         ((line_reg >= EFX_BOT) && (line_reg < ACT_END));
        end
    end

    assign bus.dmao        = dmao_reg;
    assign bus.int_n       = int_n_reg;
    assign bus.efx         = efx_reg;
    assign bus.fb_write_en = fb_write_en_reg;
    assign bus.fb_addr     = fb_addr_reg;
    assign bus.fb_data     = fb_data_reg;
endmodule

// File: tb/tb_pixie_dma_fb_writer.sv
// Directed bench for pixie_dma_fb_writer: frame timing, DMA capture addressing,
// display enable/disable behaviour and asynchronous reset.
`timescale 1ns/1ps
module tb_pixie_dma_fb_writer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    pixie_dma_fb_writer_if bus();

    pixie_dma_fb_writer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference timing state, advanced once per machine cycle
    int m_line, m_cycle, m_bytes, m_dcount;
    bit m_en;
    int dmao_bad, int_bad, efx_bad, dmao_seen, int_low, efx_high;

    logic [9:0] got_addr_q[$];
    logic [7:0] got_data_q[$];

    always @(negedge clk) begin
        if (bus.fb_write_en === 1'b1) begin
            got_addr_q.push_back(bus.fb_addr);
            got_data_q.push_back(bus.fb_data);
            $display("write addr=0x%03h data=0x%02h", bus.fb_addr, bus.fb_data);
        end
    end

    function automatic bit m_active();
        return (m_line >= 64) && (m_line < 192);
    endfunction

    task automatic clear_stats();
        dmao_bad = 0; int_bad = 0; efx_bad = 0;
        dmao_seen = 0; int_low = 0; efx_high = 0;
        got_addr_q.delete();
        got_data_q.delete();
    endtask

    task automatic do_reset();
        bus.ce = 1'b0; bus.sc = 2'b00; bus.data = 8'h00;
        bus.disp_on = 1'b0; bus.disp_off = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_line = 0; m_cycle = 0; m_bytes = 0; m_dcount = 0; m_en = 1'b0;
        clear_stats();
        @(negedge clk);
    endtask

    task automatic disp(input bit on, input bit off);
        @(negedge clk);
        bus.disp_on = on; bus.disp_off = off;
        @(negedge clk);
        bus.disp_on = 1'b0; bus.disp_off = 1'b0;
        if (off) m_en = 1'b0;
        else if (on) m_en = 1'b1;
        @(negedge clk);
    endtask

    // one machine cycle; outputs are sampled two clocks after the ce edge
    task automatic step(input bit dma, input logic [7:0] d);
        bit exp_dmao, exp_int_n, exp_efx;
        @(negedge clk);
        bus.ce = 1'b1; bus.sc = dma ? 2'b10 : 2'b00; bus.data = d;
        if (dma) m_dcount++;
        if (dma && m_en && m_active() && m_bytes < 8) m_bytes++;
        @(negedge clk);
        bus.ce = 1'b0; bus.sc = 2'b00; bus.data = 8'h00;
        m_cycle++;
        if (m_cycle == 14) begin
            m_cycle = 0; m_bytes = 0; m_line = (m_line + 1) % 262;
        end
        @(negedge clk);
        exp_dmao  = m_en && m_active() && (m_cycle >= 2) && (m_bytes < 8);
        exp_int_n = !(m_en && (m_line == 62 || m_line == 63));
        exp_efx   = (m_line >= 60 && m_line < 64) || (m_line >= 188 && m_line < 192);
        if (bus.dmao !== exp_dmao) dmao_bad++;
        if (bus.int_n !== exp_int_n) int_bad++;
        if (bus.efx !== exp_efx) efx_bad++;
        if (bus.dmao === 1'b1) dmao_seen++;
        if (bus.int_n === 1'b0) int_low++;
        if (bus.efx === 1'b1) efx_high++;
    endtask

    // mode 0: no DMA, 1: answer dmao, 2: force DMA every cycle
    task automatic run_to(input int l, input int c, input int mode);
        int guard = 0;
        while (!(m_line == l && m_cycle == c) && guard < 4000) begin
            step(mode == 2 ? 1'b1 : (mode == 1 ? (bus.dmao === 1'b1) : 1'b0), 8'(m_dcount * 37 + 5));
            guard++;
        end
    endtask

    task automatic test_reset();
        bus.ce = 1'b0; bus.sc = 2'b00; bus.data = 8'h00;
        bus.disp_on = 1'b0; bus.disp_off = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.dmao, bus.int_n, bus.efx, bus.fb_write_en} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0100", {bus.dmao, bus.int_n, bus.efx, bus.fb_write_en});
        end
        checks++;
        if ({bus.fb_addr, bus.fb_data} !== 18'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=0x%03h data=0x%02h expected 0", bus.fb_addr, bus.fb_data);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        int fl = -1, fc = -1, abad = 0, dbad = 0;
        bit found = 1'b0;
        do_reset();
        disp(1'b1, 1'b0);
        for (int k = 0; k < 262 * 14; k++) begin
            if (!found && bus.dmao === 1'b1) begin
                fl = m_line; fc = m_cycle; found = 1'b1;
            end
            step(bus.dmao === 1'b1, 8'(m_dcount * 37 + 5));
        end
        checks++;
        if (got_addr_q.size() !== 1024) begin
            errors++;
            $display("FAIL frame_writes: got %0d expected 1024", got_addr_q.size());
        end
        for (int k = 0; k < got_addr_q.size(); k++) begin
            if (got_addr_q[k] !== 10'(k)) abad++;
            if (got_data_q[k] !== 8'(k * 37 + 5)) dbad++;
        end
        checks++;
        if (abad !== 0) begin
            errors++;
            $display("FAIL frame_addr_order: got %0d bad addresses expected 0", abad);
        end
        checks++;
        if (dbad !== 0) begin
            errors++;
            $display("FAIL frame_data: got %0d bad bytes expected 0", dbad);
        end
        checks++;
        if (fl !== 64 || fc !== 2) begin
            errors++;
            $display("FAIL first_dmao: got line %0d cycle %0d expected line 64 cycle 2", fl, fc);
        end
        checks++;
        if (got_addr_q.size() > 0 && got_addr_q[0] !== 10'h000) begin
            errors++;
            $display("FAIL first_addr: got 0x%03h expected 0x000", got_addr_q[0]);
        end
        checks++;
        if (dmao_bad !== 0) begin
            errors++;
            $display("FAIL frame_dmao: got %0d bad cycles expected 0", dmao_bad);
        end
        $display("test_full_frame done writes=%0d", got_addr_q.size());
    endtask

    task automatic test_int_efx();
        do_reset();
        disp(1'b1, 1'b0);
        run_to(61, 13, 0);
        checks++;
        if (bus.int_n !== 1'b1) begin
            errors++;
            $display("FAIL int_line61: got %b expected 1", bus.int_n);
        end
        step(1'b0, 8'h00);
        checks++;
        if (bus.int_n !== 1'b0) begin
            errors++;
            $display("FAIL int_line62: got %b expected 0", bus.int_n);
        end
        run_to(64, 0, 0);
        checks++;
        if (bus.int_n !== 1'b1) begin
            errors++;
            $display("FAIL int_line64: got %b expected 1", bus.int_n);
        end
        run_to(0, 0, 0);
        checks++;
        if (int_low !== 28) begin
            errors++;
            $display("FAIL int_low_cycles: got %0d expected 28", int_low);
        end
        checks++;
        if (efx_high !== 112) begin
            errors++;
            $display("FAIL efx_high_cycles: got %0d expected 112", efx_high);
        end
        checks++;
        if (int_bad !== 0 || efx_bad !== 0) begin
            errors++;
            $display("FAIL int_efx_window: got int_bad=%0d efx_bad=%0d expected 0", int_bad, efx_bad);
        end
        $display("test_int_efx done");
    endtask

    task automatic test_disp_off_mid_line();
        int bad = 0;
        do_reset();
        disp(1'b1, 1'b0);
        run_to(100, 2, 1);
        got_addr_q.delete();
        got_data_q.delete();
        repeat (3) step(1'b1, 8'(m_dcount * 37 + 5));
        checks++;
        if (bus.dmao !== 1'b1) begin
            errors++;
            $display("FAIL dmao_before_off: got %b expected 1", bus.dmao);
        end
        disp(1'b0, 1'b1);
        checks++;
        if (bus.dmao !== 1'b0) begin
            errors++;
            $display("FAIL dmao_after_off: got %b expected 0", bus.dmao);
        end
        dmao_seen = 0; int_low = 0;
        run_to(65, 4, 2);
        checks++;
        if (got_addr_q.size() !== 3) begin
            errors++;
            $display("FAIL off_write_count: got %0d expected 3", got_addr_q.size());
        end
        for (int k = 0; k < 3 && k < got_addr_q.size(); k++)
            if (got_addr_q[k] !== 10'(12'h120 + k)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL off_write_addr: got %0d bad expected 0", bad);
        end
        checks++;
        if (dmao_seen !== 0 || int_low !== 0) begin
            errors++;
            $display("FAIL disabled_outputs: got dmao=%0d int_low=%0d expected 0", dmao_seen, int_low);
        end
        disp(1'b1, 1'b0);
        repeat (9) step(1'b1, 8'(m_dcount * 37 + 5));
        checks++;
        if (got_addr_q.size() !== 11) begin
            errors++;
            $display("FAIL resume_write_count: got %0d expected 11", got_addr_q.size());
        end
        bad = 0;
        for (int k = 3; k < 11 && k < got_addr_q.size(); k++)
            if (got_addr_q[k] !== 10'(k + 5)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL resume_write_addr: got %0d bad expected 0", bad);
        end
        checks++;
        if (dmao_bad !== 0 || int_bad !== 0) begin
            errors++;
            $display("FAIL off_timing: got dmao_bad=%0d int_bad=%0d expected 0", dmao_bad, int_bad);
        end
        $display("test_disp_off_mid_line done");
    endtask

    task automatic test_partial_line();
        logic [9:0] want[13];
        int served = 0, bad = 0;
        bit dma;
        for (int i = 0; i < 13; i++)
            want[i] = (i < 5) ? 10'(12'h030 + i) : 10'(12'h038 + i - 5);
        do_reset();
        disp(1'b1, 1'b0);
        run_to(70, 0, 0);
        got_addr_q.delete();
        got_data_q.delete();
        for (int k = 0; k < 14; k++) begin
            dma = (bus.dmao === 1'b1) && (served < 5);
            if (dma) served++;
            step(dma, 8'(m_dcount * 37 + 5));
        end
        run_to(72, 0, 1);
        checks++;
        if (got_addr_q.size() !== 13) begin
            errors++;
            $display("FAIL partial_count: got %0d expected 13", got_addr_q.size());
        end
        for (int i = 0; i < 13 && i < got_addr_q.size(); i++)
            if (got_addr_q[i] !== want[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL partial_addr: got %0d bad expected 0", bad);
        end
        checks++;
        if (dmao_bad !== 0) begin
            errors++;
            $display("FAIL partial_dmao: got %0d bad cycles expected 0", dmao_bad);
        end
        $display("test_partial_line done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        disp(1'b1, 1'b1);
        run_to(66, 0, 2);
        disp(1'b1, 1'b0);
        disp(1'b1, 1'b1);
        run_to(67, 0, 2);
        checks++;
        if (dmao_seen !== 0) begin
            errors++;
            $display("FAIL simul_dmao: got %0d asserted cycles expected 0", dmao_seen);
        end
        checks++;
        if (got_addr_q.size() !== 0) begin
            errors++;
            $display("FAIL simul_writes: got %0d expected 0", got_addr_q.size());
        end
        checks++;
        if (int_low !== 0) begin
            errors++;
            $display("FAIL simul_int: got %0d low cycles expected 0", int_low);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_reset_mid_line();
        do_reset();
        disp(1'b1, 1'b0);
        run_to(150, 4, 1);
        @(negedge clk);
        bus.ce = 1'b1; bus.sc = 2'b10; bus.data = 8'hC3;
        @(posedge clk);
        #1;
        bus.ce = 1'b0; bus.sc = 2'b00; bus.data = 8'h00;
        checks++;
        if ({bus.fb_write_en, bus.fb_addr, bus.fb_data} !== {1'b1, 10'h2B2, 8'hC3}) begin
            errors++;
            $display("FAIL pre_reset_write: got en=%b addr=0x%03h data=0x%02h expected 1 0x2b2 0xc3",
                     bus.fb_write_en, bus.fb_addr, bus.fb_data);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.dmao, bus.int_n, bus.efx, bus.fb_write_en, bus.fb_addr, bus.fb_data} !== {4'b0100, 18'h0}) begin
            errors++;
            $display("FAIL async_reset: got dmao=%b int_n=%b efx=%b en=%b addr=0x%03h data=0x%02h expected 0 1 0 0 0 0",
                     bus.dmao, bus.int_n, bus.efx, bus.fb_write_en, bus.fb_addr, bus.fb_data);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_line = 0; m_cycle = 0; m_bytes = 0; m_en = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.dmao, bus.int_n, bus.efx, bus.fb_write_en} !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 0100", {bus.dmao, bus.int_n, bus.efx, bus.fb_write_en});
        end
        run_to(65, 0, 2);
        checks++;
        if (got_addr_q.size() !== 0 || dmao_seen !== 0) begin
            errors++;
            $display("FAIL post_reset_disabled: got writes=%0d dmao=%0d expected 0", got_addr_q.size(), dmao_seen);
        end
        checks++;
        if (efx_bad !== 0 || int_bad !== 0 || efx_high !== 56) begin
            errors++;
            $display("FAIL post_reset_restart: got efx_bad=%0d int_bad=%0d efx_high=%0d expected 0 0 56",
                     efx_bad, int_bad, efx_high);
        end
        $display("test_reset_mid_line done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_int_efx();
        test_disp_off_mid_line();
        test_partial_line();
        test_simultaneous();
        test_reset_mid_line();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pixie_dma_fb_writer.md
# pixie_dma_fb_writer

CPU-side front end of the dual-port PIXIE graphics core: emulates CDP1861 machine-cycle timing toward the CDP1802 (DMA-out request, interrupt, EF1 flag) and writes each DMA-out byte into the dual-port framebuffer. The video back end reads that framebuffer independently on its own pixel timing. The block sits between the CPU bus and the write port of the 1 KiB framebuffer RAM.

## Interface
- cycles_per_line, 14, machine cycles per scan line
- lines_per_frame, 262, scan lines per frame
- first_active_line, 64, first line that fetches display data
- active_lines, 128, number of display lines (framebuffer rows)
- bytes_per_line, 8, DMA bytes per display line
- dma_start_cycle, 2, line cycle at which dmao first asserts

- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  one-clk pulse per CPU machine cycle; all timing advances only on ce
- sc  in  2  CPU state code; 2'b10 = DMA cycle
- data  in  8  CPU data bus, valid when ce and sc==2'b10
- disp_on  in  1  one-clk pulse: enable display (CPU INP 1)
- disp_off  in  1  one-clk pulse: disable display (CPU OUT 1)
- dmao  out  1  DMA-out request to CPU
- int_n  out  1  interrupt request, active-low
- efx  out  1  frame flag to CPU EF1, active-high
- fb_write_en  out  1  framebuffer write strobe, one clk
- fb_addr  out  10  framebuffer write address {row[6:0], byte[2:0]}
- fb_data  out  8  framebuffer write data

## Operation
- Cycle counter 0..cycles_per_line-1 and line counter 0..lines_per_frame-1 advance on ce; cycle wraps to 0 and increments line; line wraps from lines_per_frame-1 to 0.
- Display-enable flag: set by disp_on, cleared by disp_off; disp_off wins if both in same clk. Counters and efx run regardless of flag.
- Active line: first_active_line <= line < first_active_line+active_lines; row = line - first_active_line (7 bits).
- Byte counter 0..bytes_per_line cleared at every cycle-0 ce.
- dmao = enabled & active line & cycle >= dma_start_cycle & byte counter < bytes_per_line.
- Capture: on ce with sc==2'b10 while enabled, active line, byte counter < 8: fb_write_en pulses, fb_addr = {row, byte counter[2:0]}, fb_data = data, byte counter increments. DMA cycles at any other time are ignored (no write).
- Bytes not fetched by end of line are left unwritten; counter resets next line.
- int_n low when enabled and line in {first_active_line-2, first_active_line-1}.
- efx high when line in [first_active_line-4, first_active_line-1] or [first_active_line+active_lines-4, first_active_line+active_lines-1].

## Timing
- Reset (reset_n low, async): counters 0, enable 0, dmao 0, int_n 1, efx 0, fb_write_en 0, fb_addr 0, fb_data 0. Reset mid-line aborts line; no partial write issued.
- dmao, int_n, efx are registered: reflect counter/flag state one clk after the update that changes them.
- fb_write_en asserted exactly one clk, in the clk after the capturing ce; fb_addr/fb_data hold until next write.
- disp_off mid-line: dmao low next clk; subsequent DMA cycles on that line write nothing.
- disp_on mid-line: DMA resumes on the current line if cycle and byte count allow; rows are not re-aligned.
- ce held low: all outputs hold; no writes.
- Ninth DMA cycle in one line: ignored, byte counter saturates at 8.

## Test plan
- Reset, disp_on, then 262×14 ce pulses with CPU answering every dmao with sc=2'b10 -> exactly 1024 writes, addresses 0..1023 in order, line 64 cycle 2 first write addr 0x000, data matched.
- Enabled, count to line 62 -> int_n low for lines 62-63 (28 ce), high at line 64 cycle 0; efx high lines 60-63 and 188-191 only.
- disp_off at line 100 after 3 DMA bytes -> writes to 0x120..0x122 only, dmao low next clk, no writes until disp_on; int_n stays high next frame.
- CPU services only 5 of 8 requests on line 70 -> addresses 0x030..0x034 written, next line starts at 0x038.
- Simultaneous disp_on and disp_off -> display stays disabled, dmao never asserts.
- reset_n pulsed low at line 150 cycle 5 -> all outputs to reset values immediately; after release counting restarts at line 0 cycle 0, disabled.
